ifetch_bridge: RTL and testbench

IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

---
 rtl/ifetch_bridge.sv | 117 +++++++++++
 tb/tb_ifetch_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge: one-entry result buffer in front of an SRAM-like bus, one outstanding read.
// Optional feature macro: IFETCH_ADDR_CHECK_EN (misaligned pc answered locally with instr=0).
module ifetch_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instr,
    output logic        i_data_ok
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        stale_q, stale_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] tag_q,   tag_d;
    logic [31:0] data_q,  data_d;

    logic addr_err;
    logic hit;
    logic pc_match;
    logic bypass;
    logic miss_start;

`ifdef IFETCH_ADDR_CHECK_EN
    assign addr_err = (pc[1:0] != 2'b00);
`else
    assign addr_err = 1'b0;
`endif

    assign hit        = valid_q && (tag_q == pc) && !flush;
    assign pc_match   = (pc == addr_q);
    assign bypass     = (state_q == S_WAIT) && inst_data_ok && !stale_q && pc_match && !flush;
    assign miss_start = (state_q == S_IDLE) && !hit && !flush && !addr_err;

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;
    assign inst_addr  = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            stale_q <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            stale_q <= stale_d;
            addr_q  <= addr_d;
        end
    end

    // Buffer payload carries no reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (miss_start)   state_d = S_REQ;
            S_REQ:   if (inst_addr_ok) state_d = S_WAIT;
            S_WAIT:  if (inst_data_ok) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        stale_d = stale_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (state_q == S_IDLE) begin
            if (miss_start) begin
                addr_d  = pc;
                stale_d = 1'b0;
            end
        end else if (flush || !pc_match) begin
            // Sticky: a response for an abandoned pc must never reach the pipeline.
            stale_d = 1'b1;
        end
        if (bypass) begin
            valid_d = 1'b1;
            tag_d   = addr_q;
            data_d  = inst_rdata;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        inst_req  = (state_q == S_REQ);
        i_data_ok = addr_err || hit || bypass;
        instr     = inst_rdata;
        if (addr_err) begin
            instr = 32'h0;
        end else if (hit) begin
            instr = data_q;
        end
    end

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed table-driven bench for ifetch_bridge: one vector per clock cycle, outputs checked before the edge.
module tb_ifetch_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] instr;
    logic        i_data_ok;

    int n_cmp = 0;
    int n_err = 0;

    ifetch_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .instr        (instr),
        .i_data_ok    (i_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        flush;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        edok;
        logic [31:0] einstr;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] PA = 32'hBFC0_0000;
    localparam logic [31:0] PB = 32'hBFC0_0004;
    localparam logic [31:0] PC = 32'hBFC0_0008;
    localparam logic [31:0] PM = 32'hBFC0_0002;

    task automatic add(input logic rst, input logic [31:0] p, input logic fl, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic ereq,
                       input logic [31:0] eaddr, input logic edok, input logic [31:0] einstr);
        vec_t v;
        v.rst = rst; v.pc = p; v.flush = fl; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.edok = edok; v.einstr = einstr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // rst pc flush aok dok rdata | req addr dok instr
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 0 IDLE miss
        add(0, PA, 0, 1, 0, 32'h0,         1, PA,    0, 32'h0);         // 1 REQ, addr_ok
        add(0, PA, 0, 0, 1, 32'h3C08BFC0,  0, 32'h0, 1, 32'h3C08BFC0);  // 2 WAIT bypass
        for (int k = 0; k < 5; k++)
            add(0, PA, 0, 0, 0, 32'h0,     0, 32'h0, 1, 32'h3C08BFC0);  // 3..7 buffer hit
        add(0, PC, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 8 miss on PC
        add(0, PC, 0, 1, 0, 32'h0,         1, PC,    0, 32'h0);         // 9 REQ
        add(0, PB, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 10 WAIT, pc moves
        add(0, PB, 0, 0, 1, 32'h11111111,  0, 32'h0, 0, 32'h0);         // 11 stale data dropped
        add(0, PB, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 12 IDLE miss PB
        add(0, PB, 0, 0, 0, 32'h0,         1, PB,    0, 32'h0);         // 13 REQ, addr_ok withheld
        add(0, PB, 1, 0, 0, 32'h0,         1, PB,    0, 32'h0);         // 14 flush in REQ
        add(0, PA, 0, 0, 0, 32'h0,         1, PB,    0, 32'h0);         // 15 pc change, addr holds
        add(0, PB, 0, 1, 0, 32'h0,         1, PB,    0, 32'h0);         // 16 addr_ok
        add(0, PB, 0, 0, 1, 32'h22222222,  0, 32'h0, 0, 32'h0);         // 17 discarded
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 18 PA misses: flush invalidated
        add(0, PA, 0, 1, 0, 32'h0,         1, PA,    0, 32'h0);         // 19
        add(0, PA, 0, 0, 1, 32'h33333333,  0, 32'h0, 1, 32'h33333333);  // 20
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h33333333);  // 21 hit
        add(0, PB, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 22 miss PB
        add(0, PB, 0, 1, 0, 32'h0,         1, PB,    0, 32'h0);         // 23
        add(1, PB, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 24 reset in WAIT
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 25 valid cleared by reset
        add(0, PA, 0, 0, 0, 32'h0,         1, PA,    0, 32'h0);         // 26
        add(0, PA, 0, 1, 0, 32'h0,         1, PA,    0, 32'h0);         // 27
        add(0, PA, 0, 0, 1, 32'h44444444,  0, 32'h0, 1, 32'h44444444);  // 28
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h44444444);  // 29 hit
        add(0, PA, 1, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 30 flush masks hit
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 31 miss after flush
        add(0, PA, 0, 1, 0, 32'h0,         1, PA,    0, 32'h0);         // 32
        add(0, PA, 0, 0, 1, 32'h55555555,  0, 32'h0, 1, 32'h55555555);  // 33
`ifdef IFETCH_ADDR_CHECK_EN
        add(0, PM, 0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0);         // 34 misaligned
        add(0, PM, 0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h0);         // 35 still no req
        add(0, PM, 0, 0, 1, 32'h66666666,  0, 32'h0, 1, 32'h0);         // 36
`else
        add(0, PM, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 34 misaligned miss
        add(0, PM, 0, 1, 0, 32'h0,         1, PA,    0, 32'h0);         // 35 aligned addr
        add(0, PM, 0, 0, 1, 32'h66666666,  0, 32'h0, 1, 32'h66666666);  // 36
`endif
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h55555555);  // 37 PA still buffered? see below
        tbl.delete(tbl.size() - 1);
`ifdef IFETCH_ADDR_CHECK_EN
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h55555555);  // 37 buffer kept PA
`else
        add(0, PA, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0);         // 37 buffer replaced by PM
`endif

        reset        = 1'b1;
        pc           = PA;
        flush        = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset inst_req",   {31'h0, inst_req},  32'h0);
        chk("reset i_data_ok",  {31'h0, i_data_ok}, 32'h0);
        chk("reset inst_addr",  inst_addr,          32'h0);
        chk("const inst_wr",    {31'h0, inst_wr},   32'h0);
        chk("const inst_size",  {30'h0, inst_size}, 32'h2);
        chk("const inst_wdata", inst_wdata,         32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset        = tbl[i].rst;
            pc           = tbl[i].pc;
            flush        = tbl[i].flush;
            inst_addr_ok = tbl[i].aok;
            inst_data_ok = tbl[i].dok;
            inst_rdata   = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d inst_req", i),  {31'h0, inst_req},  {31'h0, tbl[i].ereq});
            chk($sformatf("v%0d i_data_ok", i), {31'h0, i_data_ok}, {31'h0, tbl[i].edok});
            if (tbl[i].ereq)
                chk($sformatf("v%0d inst_addr", i), inst_addr, tbl[i].eaddr);
            if (tbl[i].edok)
                chk($sformatf("v%0d instr", i), instr, tbl[i].einstr);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
